run_dump_checker: RTL and testbench
===================================

Name: run_dump_checker

Overview:
Synthesizable run controller and register-file checker for the pipelined MIPS core. It counts executed cycles up to a run-time end cycle, then halts the core and lets the pipeline drain. It then walks the register file through a read port and compares each register against an expected-value memory under a per-register mask. Results come out as pass/fail, an error count and the first failing index; an optional ready/valid stream carries every register value out for logging.

Parameters:
REG_COUNT, 32, registers walked (index 0..REG_COUNT-1); must be >=2
DATA_W, 32, register data width
CYCLE_W, 16, cycle counter / end-cycle width
DRAIN_CYCLES, 4, cycles halt_o is held before the first register read; 0 allowed
AW, clog2(REG_COUNT), address width (derived, not overridden)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
en_i  in  1  core advanced this cycle; gates cycle counting
end_cycle_i  in  CYCLE_W  run length in enabled cycles; held stable while running
cmp_mask_i  in  REG_COUNT  bit i=1: compare register i
stream_en_i  in  1  emit every register on the dump stream
halt_o  out  1  freeze core fetch/commit
cycle_o  out  CYCLE_W  enabled cycles counted
rf_addr_o  out  AW  register-file and expected-memory read address
rf_data_i  in  DATA_W  register data, valid one cycle after rf_addr_o
exp_data_i  in  DATA_W  expected data, same timing as rf_data_i
dump_valid_o  out  1  stream beat valid
dump_ready_i  in  1  stream sink ready
dump_addr_o  out  AW  register index of beat
dump_data_o  out  DATA_W  register value of beat
done_o  out  1  check complete (sticky)
pass_o  out  1  done_o and zero errors
err_count_o  out  AW+1  number of mismatching compared registers
first_err_addr_o  out  AW  lowest failing index; meaningful only when err_count_o>0

Behaviour:
- Reset (rst_i=0, immediate, asynchronous): state RUN, cycle_o=0, halt_o=0, rf_addr_o=0, dump_valid_o=0, dump_addr_o=0, dump_data_o=0, done_o=0, pass_o=0, err_count_o=0, first_err_addr_o=0.
- States: RUN, DRAIN, READ, CHECK, EMIT, DONE.
- RUN: cycle_o increments on each edge with en_i=1 and saturates at all-ones. Move to DRAIN on the edge where cycle_o+1==end_cycle_i and en_i=1. With end_cycle_i==0, move to DRAIN on the first edge after reset regardless of en_i.
- halt_o=1 in every state except RUN, registered. It rises the cycle after the final counted cycle.
- DRAIN: internal counter runs DRAIN_CYCLES edges, then moves to READ with index=0. With DRAIN_CYCLES=0, READ follows RUN directly.
- READ (1 cycle): rf_addr_o=index, then CHECK.
- CHECK (1 cycle): rf_data_i and exp_data_i are sampled. If cmp_mask_i[index] and the data differ: err_count_o increments, and if this is the first error, first_err_addr_o=index. Value and index are latched for the stream.
  - stream_en_i=1: go to EMIT.
  - Otherwise: if index==REG_COUNT-1 go to DONE, else index+1 and go to READ.
- EMIT: dump_valid_o=1 with dump_addr_o/dump_data_o stable until the edge where dump_ready_i=1. On that edge valid drops, then DONE or READ as in CHECK. No combinational path from dump_ready_i to outputs.
- Per-register latency: 2 cycles without streaming; 2 plus the EMIT wait with streaming. The no-stream total after DRAIN is 2*REG_COUNT cycles.
- DONE: done_o=1, pass_o=(err_count_o==0). Both are registered and set on entry. Holds until reset; en_i and end_cycle_i are ignored.
- en_i and end_cycle_i are ignored outside RUN. cmp_mask_i and stream_en_i are sampled at CHECK for each register.
- Reset mid-operation: all state returns to reset values, including an in-flight stream beat, which is dropped. Counting restarts from 0 after release.

Test Plan:
- Defaults, end_cycle=100, en_i=1, rf==exp, stream off -> halt_o rises cycle 101; done_o=1 and pass_o=1 at cycle 100+4+64; err_count_o=0.
- exp differs at regs 5 and 17, mask all ones -> err_count_o=2, first_err_addr_o=5, pass_o=0.
- Same stimulus with cmp_mask_i[5]=0 -> err_count_o=1, first_err_addr_o=17.
- stream_en_i=1, dump_ready_i toggling 1-0-1-0 -> 32 beats with addr 0..31 in order; addr/data hold while valid&&!ready; done_o only after beat 31 is accepted.
- en_i low 10 of the first 50 cycles, end_cycle=20 -> halt_o rises after exactly 20 enabled cycles; cycle_o=20. end_cycle=0 -> halt_o=1 in the 2nd cycle after reset.
- rst_i pulsed low during EMIT of reg 9 -> all outputs at reset values immediately; on rerun, a full 32-register pass completes with correct counts.

Source files
------------

// File: rtl/run_dump_checker.sv
// Run controller and register-file checker for the pipelined MIPS core.
// Counts enabled core cycles up to a run-time end cycle, halts the core,
// waits for the pipeline to drain, then walks the register file comparing
// each entry against an expected-value memory under a per-register mask.
// Every register can optionally be emitted on a ready/valid dump stream.
module run_dump_checker #(
  parameter int REG_COUNT    = 32,
  parameter int DATA_W       = 32,
  parameter int CYCLE_W      = 16,
  parameter int DRAIN_CYCLES = 4,
  localparam int AW          = $clog2(REG_COUNT)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [CYCLE_W-1:0]   end_cycle_i,
  input  logic [REG_COUNT-1:0] cmp_mask_i,
  input  logic                 stream_en_i,
  output logic                 halt_o,
  output logic [CYCLE_W-1:0]   cycle_o,
  output logic [AW-1:0]        rf_addr_o,
  input  logic [DATA_W-1:0]    rf_data_i,
  input  logic [DATA_W-1:0]    exp_data_i,
  output logic                 dump_valid_o,
  input  logic                 dump_ready_i,
  output logic [AW-1:0]        dump_addr_o,
  output logic [DATA_W-1:0]    dump_data_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [AW:0]          err_count_o,
  output logic [AW-1:0]        first_err_addr_o
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
  localparam logic [AW-1:0]  LAST_IDX   = AW'(REG_COUNT - 1);

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN,
    S_READ,
    S_CHECK,
    S_EMIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CYCLE_W-1:0]  cycle_q, cycle_d;
  logic [DCW-1:0]      drain_q, drain_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic                halt_q, halt_d;
  logic                dump_valid_q, dump_valid_d;
  logic [AW-1:0]       dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [AW:0]         err_q, err_d;
  logic [AW-1:0]       first_q, first_d;
  logic                advance;
  logic [CYCLE_W:0]    cycle_inc;
  logic [CYCLE_W:0]    end_ext;
  state_e              post_run;

  // One bit wider than the counter so a saturated count never aliases end_cycle_i.
  assign cycle_inc = {1'b0, cycle_q} + (CYCLE_W + 1)'(1);
  assign end_ext   = {1'b0, end_cycle_i};
  assign post_run  = (DRAIN_CYCLES == 0) ? S_READ : S_DRAIN;

  // Next-state and datapath updates for the run / drain / walk sequence.
  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    drain_d      = drain_q;
    idx_d        = idx_q;
    dump_valid_d = dump_valid_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_d        = err_q;
    first_d      = first_q;
    advance      = 1'b0;

    case (state_q)
      S_RUN: begin
        if (end_cycle_i == '0) begin
          state_d = post_run;
          drain_d = '0;
          idx_d   = '0;
        end else if (en_i) begin
          if (cycle_q != '1) begin
            cycle_d = cycle_q + CYCLE_W'(1);
          end
          if (cycle_inc == end_ext) begin
            state_d = post_run;
            drain_d = '0;
            idx_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_READ;
          idx_d   = '0;
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      S_READ: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (cmp_mask_i[idx_q] && (rf_data_i != exp_data_i)) begin
          err_d = err_q + (AW + 1)'(1);
          if (err_q == '0) begin
            first_d = idx_q;
          end
        end
        dump_addr_d = idx_q;
        dump_data_d = rf_data_i;
        if (stream_en_i) begin
          state_d      = S_EMIT;
          dump_valid_d = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      S_EMIT: begin
        if (dump_ready_i) begin
          dump_valid_d = 1'b0;
          advance      = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        pass_d  = (err_d == '0);
      end else begin
        idx_d   = idx_q + AW'(1);
        state_d = S_READ;
      end
    end
  end

  // Halt is registered and follows the state leaving RUN.
  assign halt_d = (state_d != S_RUN);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_RUN;
      cycle_q      <= '0;
      drain_q      <= '0;
      idx_q        <= '0;
      halt_q       <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      first_q      <= '0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      drain_q      <= drain_d;
      idx_q        <= idx_d;
      halt_q       <= halt_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      first_q      <= first_d;
    end
  end

  assign halt_o           = halt_q;
  assign cycle_o          = cycle_q;
  assign rf_addr_o        = idx_q;
  assign dump_valid_o     = dump_valid_q;
  assign dump_addr_o      = dump_addr_q;
  assign dump_data_o      = dump_data_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_run_dump_checker.sv
// Directed testbench for run_dump_checker with a synchronous register-file
// and expected-value memory model.
module tb_run_dump_checker;

  localparam int REG_COUNT = 32;
  localparam int DATA_W    = 32;
  localparam int CYCLE_W   = 16;
  localparam int AW        = 5;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 en_i = 1'b0;
  logic [CYCLE_W-1:0]   end_cycle_i = '0;
  logic [REG_COUNT-1:0] cmp_mask_i = '1;
  logic                 stream_en_i = 1'b0;
  logic                 halt_o;
  logic [CYCLE_W-1:0]   cycle_o;
  logic [AW-1:0]        rf_addr_o;
  logic [DATA_W-1:0]    rf_data_i;
  logic [DATA_W-1:0]    exp_data_i;
  logic                 dump_valid_o;
  logic                 dump_ready_i = 1'b0;
  logic [AW-1:0]        dump_addr_o;
  logic [DATA_W-1:0]    dump_data_o;
  logic                 done_o;
  logic                 pass_o;
  logic [AW:0]          err_count_o;
  logic [AW-1:0]        first_err_addr_o;

  logic [DATA_W-1:0] rf_mem  [REG_COUNT];
  logic [DATA_W-1:0] exp_mem [REG_COUNT];

  int vectors = 0;
  int miscompares = 0;

  run_dump_checker #(
    .REG_COUNT(REG_COUNT),
    .DATA_W(DATA_W),
    .CYCLE_W(CYCLE_W),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i(en_i),
    .end_cycle_i(end_cycle_i),
    .cmp_mask_i(cmp_mask_i),
    .stream_en_i(stream_en_i),
    .halt_o(halt_o),
    .cycle_o(cycle_o),
    .rf_addr_o(rf_addr_o),
    .rf_data_i(rf_data_i),
    .exp_data_i(exp_data_i),
    .dump_valid_o(dump_valid_o),
    .dump_ready_i(dump_ready_i),
    .dump_addr_o(dump_addr_o),
    .dump_data_o(dump_data_o),
    .done_o(done_o),
    .pass_o(pass_o),
    .err_count_o(err_count_o),
    .first_err_addr_o(first_err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  // Register file and expected memory both return data one cycle after the address.
  always @(posedge clk_i) begin
    rf_data_i  <= rf_mem[rf_addr_o];
    exp_data_i <= exp_mem[rf_addr_o];
  end

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic load_mems(input int errA, input int errB);
    for (int i = 0; i < REG_COUNT; i++) begin
      rf_mem[i]  = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
      exp_mem[i] = rf_mem[i];
    end
    if (errA >= 0) exp_mem[errA] = exp_mem[errA] ^ 32'h0000_0100;
    if (errB >= 0) exp_mem[errB] = exp_mem[errB] ^ 32'h0040_0000;
  endtask

  // Holds reset for two cycles, then releases on a falling edge; the next rising edge is edge 1.
  task automatic start_run(input logic [CYCLE_W-1:0] endc, input logic en, input logic stream);
    @(negedge clk_i);
    rst_i        = 1'b0;
    end_cycle_i  = endc;
    en_i         = en;
    stream_en_i  = stream;
    dump_ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (done_o) ok = 1'b1;
  endtask

  task automatic test_reset();
    en_i = 1'b1;
    end_cycle_i = 16'd3;
    #2 rst_i = 1'b0;
    tick();
    tick();
    vectors++;
    if (halt_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_halt: got %0b expected 0", halt_o);
    end
    vectors++;
    if (cycle_o !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_cycle: got %0d expected 0", cycle_o);
    end
    vectors++;
    if ({done_o, pass_o, err_count_o, first_err_addr_o} !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_result: got done=%0b pass=%0b err=%0d first=%0d expected all 0",
               done_o, pass_o, err_count_o, first_err_addr_o);
    end
    vectors++;
    if ({dump_valid_o, dump_addr_o, dump_data_o, rf_addr_o} !== 43'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_stream: got valid=%0b addr=%0d data=%h rf_addr=%0d expected all 0",
               dump_valid_o, dump_addr_o, dump_data_o, rf_addr_o);
    end
  endtask

  task automatic test_basic();
    load_mems(-1, -1);
    cmp_mask_i = '1;
    start_run(16'd100, 1'b1, 1'b0);
    repeat (99) tick();
    vectors++;
    if (halt_o !== 1'b0 || cycle_o !== 16'd99) begin
      miscompares++;
      $display("[TB] FAIL basic_edge99: got halt=%0b cycle=%0d expected halt=0 cycle=99", halt_o, cycle_o);
    end
    tick();
    vectors++;
    if (halt_o !== 1'b1 || cycle_o !== 16'd100) begin
      miscompares++;
      $display("[TB] FAIL basic_edge100: got halt=%0b cycle=%0d expected halt=1 cycle=100", halt_o, cycle_o);
    end
    repeat (67) tick();
    vectors++;
    if (done_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_done_early: got done=%0b at edge 167 expected 0", done_o);
    end
    tick();
    vectors++;
    if (done_o !== 1'b1 || pass_o !== 1'b1 || err_count_o !== 6'd0 || cycle_o !== 16'd100) begin
      miscompares++;
      $display("[TB] FAIL basic_done: got done=%0b pass=%0b err=%0d cycle=%0d expected 1 1 0 100",
               done_o, pass_o, err_count_o, cycle_o);
    end
  endtask

  task automatic test_mismatch();
    bit ok;
    logic [AW:0]   expErr [3];
    logic [AW-1:0] expFirst [3];
    expErr[0] = 6'd2; expFirst[0] = 5'd5;
    expErr[1] = 6'd1; expFirst[1] = 5'd17;
    expErr[2] = 6'd2; expFirst[2] = 5'd0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) load_mems(0, 31);
      else load_mems(5, 17);
      cmp_mask_i = '1;
      if (c == 1) cmp_mask_i[5] = 1'b0;
      start_run(16'd8, 1'b1, 1'b0);
      wait_done(300, ok);
      vectors++;
      if (ok !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL mismatch_timeout case %0d: got done=%0b expected 1", c, done_o);
      end
      vectors++;
      if (err_count_o !== expErr[c] || first_err_addr_o !== expFirst[c] || pass_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL mismatch case %0d: got err=%0d first=%0d pass=%0b expected err=%0d first=%0d pass=0",
                 c, err_count_o, first_err_addr_o, pass_o, expErr[c], expFirst[c]);
      end
    end
    cmp_mask_i = '1;
  endtask

  task automatic test_stream();
    int beats = 0;
    bit holdPending = 1'b0;
    bit readyToggle = 1'b1;
    bit sawDone = 1'b0;
    logic [AW-1:0] holdA = '0;
    logic [DATA_W-1:0] holdD = '0;
    logic v;
    logic [AW-1:0] a;
    logic [DATA_W-1:0] d;
    load_mems(-1, -1);
    cmp_mask_i = '1;
    start_run(16'd6, 1'b1, 1'b1);
    for (int n = 0; n < 800; n++) begin
      v = dump_valid_o;
      a = dump_addr_o;
      d = dump_data_o;
      if (done_o) begin
        sawDone = 1'b1;
        vectors++;
        if (beats != 32 || dump_valid_o !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL stream_done_order: got beats=%0d valid=%0b at done expected 32 0", beats, dump_valid_o);
        end
        break;
      end
      if (holdPending) begin
        vectors++;
        if (v !== 1'b1 || a !== holdA || d !== holdD) begin
          miscompares++;
          $display("[TB] FAIL stream_hold: got valid=%0b addr=%0d data=%h expected 1 %0d %h", v, a, d, holdA, holdD);
        end
      end
      dump_ready_i = readyToggle;
      readyToggle = ~readyToggle;
      if (v === 1'b1 && dump_ready_i) begin
        vectors++;
        if (a !== AW'(beats) || d !== rf_mem[beats]) begin
          miscompares++;
          $display("[TB] FAIL stream_beat %0d: got addr=%0d data=%h expected addr=%0d data=%h",
                   beats, a, d, beats, rf_mem[beats]);
        end
        beats++;
      end
      holdPending = (v === 1'b1) && !dump_ready_i;
      holdA = a;
      holdD = d;
      tick();
    end
    dump_ready_i = 1'b0;
    vectors++;
    if (sawDone !== 1'b1 || pass_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stream_complete: got done=%0b pass=%0b beats=%0d expected 1 1 32", sawDone, pass_o, beats);
    end
  endtask

  task automatic test_en_gaps();
    int model = 0;
    logic en;
    load_mems(-1, -1);
    start_run(16'd20, 1'b0, 1'b0);
    for (int n = 0; n < 50; n++) begin
      en = (n % 5 != 2);
      en_i = en;
      tick();
      if (en && model < 20) model++;
      vectors++;
      if (halt_o !== (model == 20) || cycle_o !== 16'(model)) begin
        miscompares++;
        $display("[TB] FAIL en_gaps cycle %0d: got halt=%0b count=%0d expected halt=%0b count=%0d",
                 n, halt_o, cycle_o, (model == 20), model);
      end
    end
    en_i = 1'b1;
  endtask

  task automatic test_end_zero();
    start_run(16'd0, 1'b0, 1'b0);
    vectors++;
    if (halt_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL end_zero_first: got halt=%0b expected 0", halt_o);
    end
    tick();
    vectors++;
    if (halt_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL end_zero_second: got halt=%0b expected 1", halt_o);
    end
  endtask

  task automatic test_reset_mid_emit();
    bit found = 1'b0;
    bit ok;
    load_mems(3, -1);
    cmp_mask_i = '1;
    start_run(16'd4, 1'b1, 1'b1);
    for (int n = 0; n < 500; n++) begin
      if (dump_valid_o === 1'b1 && dump_addr_o == 5'd9) begin
        found = 1'b1;
        break;
      end
      dump_ready_i = (dump_valid_o === 1'b1) && (dump_addr_o < 5'd9);
      tick();
    end
    dump_ready_i = 1'b0;
    vectors++;
    if (found !== 1'b1 || err_count_o !== 6'd1) begin
      miscompares++;
      $display("[TB] FAIL midrun_reach9: got found=%0b err=%0d expected 1 1", found, err_count_o);
    end
    rst_i = 1'b0;
    #1;
    vectors++;
    if ({halt_o, cycle_o, rf_addr_o, dump_valid_o, dump_addr_o, dump_data_o,
         done_o, pass_o, err_count_o, first_err_addr_o} !== 73'd0) begin
      miscompares++;
      $display("[TB] FAIL midrun_async_reset: got halt=%0b cycle=%0d valid=%0b addr=%0d data=%h err=%0d expected all 0",
               halt_o, cycle_o, dump_valid_o, dump_addr_o, dump_data_o, err_count_o);
    end
    load_mems(3, 20);
    start_run(16'd4, 1'b1, 1'b0);
    wait_done(300, ok);
    vectors++;
    if (ok !== 1'b1 || err_count_o !== 6'd2 || first_err_addr_o !== 5'd3 || pass_o !== 1'b0 || cycle_o !== 16'd4) begin
      miscompares++;
      $display("[TB] FAIL midrun_rerun: got done=%0b err=%0d first=%0d pass=%0b cycle=%0d expected 1 2 3 0 4",
               ok, err_count_o, first_err_addr_o, pass_o, cycle_o);
    end
  endtask

  initial begin
    load_mems(-1, -1);
    test_reset();
    test_basic();
    test_mismatch();
    test_stream();
    test_en_gaps();
    test_end_zero();
    test_reset_mid_emit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
